// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: writeback has absolute priority, MDU results queue in a FIFO.
// Optional macro RFWA_FORWARD_EN enables the chk_hit/chk_data forwarding path.
module rf_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wb_we,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_reg,
    input  logic [31:0]              mdu_data,
    output logic                     RegWrite,
    output logic [4:0]               WriteReg,
    output logic [31:0]              WriteData,
    input  logic [4:0]               chk_reg,
    output logic                     chk_pending,
    output logic                     chk_hit,
    output logic [31:0]              chk_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    reg_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic wb_req;
    logic push;
    logic pop;
    logic match;
    logic [AW-1:0] scan_idx;
`ifdef RFWA_FORWARD_EN
    logic [31:0] fwd_data;
`endif

    // Writes to r0 are architecturally discarded, so they never occupy a slot.
    assign wb_req    = wb_we && (wb_reg != 5'd0);
    assign mdu_ready = (fifo_count < CW'(DEPTH));
    assign push      = mdu_valid && mdu_ready && (mdu_reg != 5'd0);
    assign pop       = !wb_req && (fifo_count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            reg_mem[wr_ptr]  <= mdu_reg;
            data_mem[wr_ptr] <= mdu_data;
        end
    end

    // Output stage and queue bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            RegWrite   <= 1'b0;
            WriteReg   <= 5'd0;
            WriteData  <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (wb_req) begin
                RegWrite  <= 1'b1;
                WriteReg  <= wb_reg;
                WriteData <= wb_data;
            end else if (pop) begin
                RegWrite  <= 1'b1;
                WriteReg  <= reg_mem[rd_ptr];
                WriteData <= data_mem[rd_ptr];
            end else begin
                RegWrite  <= 1'b0;
            end
        end
    end

    // Scan oldest to youngest so the last match is the value the register file ends up holding.
    always_comb begin
        match    = RegWrite && (WriteReg == chk_reg);
        scan_idx = rd_ptr;
`ifdef RFWA_FORWARD_EN
        fwd_data = WriteData;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + AW'(k);
            if ((CW'(k) < fifo_count) && (reg_mem[scan_idx] == chk_reg)) begin
                match = 1'b1;
`ifdef RFWA_FORWARD_EN
                fwd_data = data_mem[scan_idx];
`endif
            end
        end
    end

    assign chk_pending = (chk_reg != 5'd0) && match;

`ifdef RFWA_FORWARD_EN
    assign chk_hit  = chk_pending;
    assign chk_data = fwd_data;
`else
    assign chk_hit  = 1'b0;
    assign chk_data = 32'd0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (DEPTH=4).
module tb_rf_write_arbiter;

    logic        clock;
    logic        reset_n;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  chk_reg;
    logic        chk_pending;
    logic        chk_hit;
    logic [31:0] chk_data;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

`ifdef RFWA_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    rf_write_arbiter #(.DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .chk_reg(chk_reg), .chk_pending(chk_pending), .chk_hit(chk_hit), .chk_data(chk_data),
        .fifo_count(fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        mdu_valid = 1'b0; mdu_reg = 5'd0; mdu_data = 32'd0;
        chk_reg = 5'd0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle();
        tick(); tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0h want 0", RegWrite); end
        checks++; if (WriteReg !== 5'd0) begin errors++; $display("FAIL rst_writereg got %0h want 0", WriteReg); end
        checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL rst_writedata got %0h want 0", WriteData); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h want 1", mdu_ready); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_idle_regwrite got %0h want 0", RegWrite); end
    endtask

    task automatic test_mdu_single;
        mdu_valid = 1'b1; mdu_reg = 5'd5; mdu_data = 32'hAAAA0001;
        tick();
        mdu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_queued got %0d want 1", fifo_count); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_nowrite got %0h want 0", RegWrite); end
        tick();
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_regwrite got %0h want 1", RegWrite); end
        checks++; if (WriteReg !== 5'd5) begin errors++; $display("FAIL single_writereg got %0d want 5", WriteReg); end
        checks++; if (WriteData !== 32'hAAAA0001) begin errors++; $display("FAIL single_writedata got %0h want aaaa0001", WriteData); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count got %0d want 0", fifo_count); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_idle got %0h want 0", RegWrite); end
        checks++; if (WriteReg !== 5'd5) begin errors++; $display("FAIL single_hold got %0d want 5", WriteReg); end
    endtask

    task automatic test_wb_priority;
        int j;
        j = 0;
        for (int i = 0; i < 6; i++) begin
            wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'd100 + 32'(i);
            mdu_valid = 1'b1; mdu_reg = 5'(10 + j); mdu_data = 32'h200 + 32'(j);
            if (i >= 4) begin
                checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_full i=%0d got %0h want 0", i, mdu_ready); end
            end
            tick();
            if (i < 4) j++;
            checks++; if (WriteReg !== 5'd3 || RegWrite !== 1'b1) begin errors++; $display("FAIL prio_wb_win i=%0d got we=%0h reg=%0d want we=1 reg=3", i, RegWrite, WriteReg); end
            checks++; if (WriteData !== 32'd100 + 32'(i)) begin errors++; $display("FAIL prio_wb_data i=%0d got %0d want %0d", i, WriteData, 100 + i); end
            checks++; if (fifo_count !== 3'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL prio_count i=%0d got %0d want %0d", i, fifo_count, (i < 4) ? i + 1 : 4); end
        end
        wb_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mdu_valid = (j < 5); mdu_reg = 5'(10 + j); mdu_data = 32'h200 + 32'(j);
            checks++; if (mdu_ready !== (k != 0)) begin errors++; $display("FAIL drain_ready k=%0d got %0h want %0h", k, mdu_ready, k != 0); end
            tick();
            if (k == 1) j++;
            checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'(10 + k)) begin errors++; $display("FAIL drain_order k=%0d got we=%0h reg=%0d want we=1 reg=%0d", k, RegWrite, WriteReg, 10 + k); end
            checks++; if (WriteData !== 32'h200 + 32'(k)) begin errors++; $display("FAIL drain_data k=%0d got %0h want %0h", k, WriteData, 32'h200 + k); end
            checks++; if (fifo_count !== 3'((k < 2) ? 3 : 4 - k)) begin errors++; $display("FAIL drain_count k=%0d got %0d want %0d", k, fifo_count, (k < 2) ? 3 : 4 - k); end
        end
        mdu_valid = 1'b0;
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL drain_empty got %0h want 0", RegWrite); end
    endtask

    task automatic test_forward;
        wb_we = 1'b1; wb_reg = 5'd1; wb_data = 32'h55;
        mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h11;
        tick();
        mdu_data = 32'h22;
        tick();
        mdu_valid = 1'b0;
        chk_reg = 5'd7; #1;
        checks++; if (chk_pending !== 1'b1) begin errors++; $display("FAIL fwd_pending got %0h want 1", chk_pending); end
        checks++; if (chk_hit !== FWD) begin errors++; $display("FAIL fwd_hit got %0h want %0h", chk_hit, FWD); end
        checks++; if (chk_data !== (FWD ? 32'h22 : 32'h0)) begin errors++; $display("FAIL fwd_youngest got %0h want %0h", chk_data, FWD ? 32'h22 : 32'h0); end
        chk_reg = 5'd1; #1;
        checks++; if (chk_pending !== 1'b1) begin errors++; $display("FAIL fwd_outstage got %0h want 1", chk_pending); end
        checks++; if (chk_data !== (FWD ? 32'h55 : 32'h0)) begin errors++; $display("FAIL fwd_outdata got %0h want %0h", chk_data, FWD ? 32'h55 : 32'h0); end
        chk_reg = 5'd9; #1;
        checks++; if (chk_pending !== 1'b0) begin errors++; $display("FAIL fwd_miss got %0h want 0", chk_pending); end
        chk_reg = 5'd0; #1;
        checks++; if (chk_pending !== 1'b0) begin errors++; $display("FAIL fwd_r0 got %0h want 0", chk_pending); end
        wb_we = 1'b0;
        chk_reg = 5'd7;
        tick();
        checks++; if (WriteData !== 32'h11 || chk_pending !== 1'b1) begin errors++; $display("FAIL fwd_pop1 got data=%0h pend=%0h want 11 1", WriteData, chk_pending); end
        checks++; if (chk_data !== (FWD ? 32'h22 : 32'h0)) begin errors++; $display("FAIL fwd_pop1_data got %0h want %0h", chk_data, FWD ? 32'h22 : 32'h0); end
        tick();
        checks++; if (chk_pending !== 1'b1 || chk_data !== (FWD ? 32'h22 : 32'h0)) begin errors++; $display("FAIL fwd_pop2 got pend=%0h data=%0h", chk_pending, chk_data); end
        tick();
        checks++; if (chk_pending !== 1'b0 || chk_hit !== 1'b0) begin errors++; $display("FAIL fwd_done got pend=%0h hit=%0h want 0 0", chk_pending, chk_hit); end
        chk_reg = 5'd0;
    endtask

    task automatic test_r0;
        wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hDEAD;
        mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'hBEEF;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL r0_handshake got %0h want 1", mdu_ready); end
        tick();
        idle();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL r0_regwrite got %0h want 0", RegWrite); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL r0_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 4; i++) begin
            wb_we = 1'b1; wb_reg = 5'd2; wb_data = 32'(i);
            mdu_valid = 1'b1; mdu_reg = 5'(20 + i); mdu_data = 32'h300 + 32'(i);
            tick();
        end
        wb_we = 1'b0;
        mdu_reg = 5'd24; mdu_data = 32'h304;
        checks++; if (mdu_ready !== 1'b0 || fifo_count !== 3'd4) begin errors++; $display("FAIL full_ready got rdy=%0h cnt=%0d want 0 4", mdu_ready, fifo_count); end
        tick();
        checks++; if (fifo_count !== 3'd3 || WriteReg !== 5'd20) begin errors++; $display("FAIL full_refused got cnt=%0d reg=%0d want 3 20", fifo_count, WriteReg); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_next got %0h want 1", mdu_ready); end
        tick();
        mdu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd3 || WriteReg !== 5'd21) begin errors++; $display("FAIL full_accept got cnt=%0d reg=%0d want 3 21", fifo_count, WriteReg); end
        for (int k = 22; k < 25; k++) begin
            tick();
            checks++; if (WriteReg !== 5'(k) || WriteData !== 32'h300 + 32'(k - 20)) begin errors++; $display("FAIL full_drain got reg=%0d data=%0h want %0d %0h", WriteReg, WriteData, k, 32'h300 + k - 20); end
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", fifo_count); end
        tick();
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            wb_we = 1'b1; wb_reg = 5'd4; wb_data = 32'hF0 + 32'(i);
            mdu_valid = 1'b1; mdu_reg = 5'(8 + i); mdu_data = 32'h400 + 32'(i);
            tick();
        end
        idle();
        checks++; if (fifo_count !== 3'd3 || RegWrite !== 1'b1) begin errors++; $display("FAIL mid_fill got cnt=%0d we=%0h want 3 1", fifo_count, RegWrite); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'd0) begin errors++; $display("FAIL mid_async got we=%0h reg=%0d data=%0h want 0 0 0", RegWrite, WriteReg, WriteData); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++; if (fifo_count !== 3'd0 || mdu_ready !== 1'b1) begin errors++; $display("FAIL mid_release got cnt=%0d rdy=%0h want 0 1", fifo_count, mdu_ready); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mid_discard got %0h want 0", RegWrite); end
    endtask

    initial begin
        test_reset();
        test_mdu_single();
        test_wb_priority();
        test_forward();
        test_r0();
        test_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
